// File: rtl/regfile_pkg.sv
// Shared constants and the reference one-hot decode for the register-file
// write-enable path.
// Pure declarations: no ports, no state.
package regfile_pkg;

    localparam int SEL_W_DEF        = 5;
    localparam int ZERO_REG_IDX_DEF = 31;
    localparam int OUT_W_DEF        = 1 << SEL_W_DEF;

    // One-hot decode of a default-width index; all-zero when not enabled.
    function automatic logic [OUT_W_DEF-1:0] onehot_decode(
        input logic [SEL_W_DEF-1:0] sel,
        input logic                 en
    );
        logic [OUT_W_DEF-1:0] vec;
        vec = '0;
        if (en) begin
            vec[sel] = 1'b1;
        end
        return vec;
    endfunction

endpackage

// File: rtl/decoder_param.sv
// Combinational SEL_W-to-OUT_W one-hot decoder with enable and optional
// hardwired-zero-register masking. Zero latency, no flow control.
// Ports: en (request), sel (index), dec (one-hot enable, zero when masked).
module decoder_param
    import regfile_pkg::*;
#(
    parameter int  SEL_W        = SEL_W_DEF,
    parameter bit  ZERO_REG_EN  = 1'b1,
    parameter int  ZERO_REG_IDX = ZERO_REG_IDX_DEF,
    localparam int OUT_W        = 1 << SEL_W
) (
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] dec
);

    localparam logic [SEL_W-1:0] ZIDX = SEL_W'(ZERO_REG_IDX);

    logic zero_hit;
    logic en_eff;

    assign zero_hit = ZERO_REG_EN && (sel == ZIDX);
    assign en_eff   = en && !zero_hit;

    // The package function is fixed at the default width; other widths
    // decode inline with identical semantics.
    if (SEL_W == SEL_W_DEF) begin : g_pkg
        assign dec = onehot_decode(sel, en_eff);
    end else begin : g_local
        always_comb begin
            dec = '0;
            if (en_eff) begin
                dec[sel] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_we_decoder.sv
// Registered multi-port write-enable decoder with low-port-wins priority and
// a saturating conflict counter. Latency 1 cycle; stall holds, flush clears
// (flush beats stall). Ports: clk, reset_n, stall, flush, wr_en, wr_sel in;
// we_port, we_any, conflict, conflict_cnt out (all registered).
module regfile_we_decoder
    import regfile_pkg::*;
#(
    parameter int  SEL_W        = SEL_W_DEF,
    parameter int  NUM_PORTS    = 2,
    parameter bit  ZERO_REG_EN  = 1'b1,
    parameter int  ZERO_REG_IDX = ZERO_REG_IDX_DEF,
    parameter int  CNT_W        = 8,
    localparam int OUT_W        = 1 << SEL_W
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       stall,
    input  logic                       flush,
    input  logic [NUM_PORTS-1:0]       wr_en,
    input  logic [NUM_PORTS*SEL_W-1:0] wr_sel,
    output logic [NUM_PORTS*OUT_W-1:0] we_port,
    output logic [OUT_W-1:0]           we_any,
    output logic                       conflict,
    output logic [CNT_W-1:0]           conflict_cnt
);

    logic [OUT_W-1:0]           raw [NUM_PORTS];
    logic [OUT_W-1:0]           claimed;
    logic [NUM_PORTS*OUT_W-1:0] we_next;
    logic                       conflict_next;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_dec
        decoder_param #(
            .SEL_W        (SEL_W),
            .ZERO_REG_EN  (ZERO_REG_EN),
            .ZERO_REG_IDX (ZERO_REG_IDX)
        ) u_dec (
            .en  (wr_en[p]),
            .sel (wr_sel[p*SEL_W +: SEL_W]),
            .dec (raw[p])
        );
    end

    // Walk ports lowest first; 'claimed' collects bits already granted, so a
    // higher port loses any bit a lower port owns. Masked zero-register hits
    // are already gone from raw, so they never register as conflicts.
    // The OR of the resolved vectors equals the OR of the raw ones.
    always_comb begin
        claimed       = '0;
        conflict_next = 1'b0;
        we_next       = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            we_next[p*OUT_W +: OUT_W] = raw[p] & ~claimed;
            if ((raw[p] & claimed) != '0) begin
                conflict_next = 1'b1;
            end
            claimed = claimed | raw[p];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_port      <= '0;
            we_any       <= '0;
            conflict     <= 1'b0;
            conflict_cnt <= '0;
        end else if (flush) begin
            // Flush drops the in-flight enables but keeps the statistic.
            we_port  <= '0;
            we_any   <= '0;
            conflict <= 1'b0;
        end else if (!stall) begin
            we_port  <= we_next;
            we_any   <= claimed;
            conflict <= conflict_next;
            if (conflict_next && (conflict_cnt != {CNT_W{1'b1}})) begin
                conflict_cnt <= conflict_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_regfile_we_decoder.sv
module tb_regfile_we_decoder;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        flush;

    // Shared stimulus for the three SEL_W=5, two-port instances.
    logic [1:0]  wr_en_a;
    logic [9:0]  wr_sel_a;

    logic [63:0] we_port_a, we_port_n, we_port_s;
    logic [31:0] we_any_a,  we_any_n,  we_any_s;
    logic        conflict_a, conflict_n, conflict_s;
    logic [7:0]  cnt_a, cnt_n;
    logic [1:0]  cnt_s;

    // Three-port, SEL_W=4 variant.
    logic [2:0]  wr_en_c;
    logic [11:0] wr_sel_c;
    logic [47:0] we_port_c;
    logic [15:0] we_any_c;
    logic        conflict_c;
    logic [7:0]  cnt_c;

    int n_vec;
    int n_err;

    regfile_we_decoder u_dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
        .wr_en(wr_en_a), .wr_sel(wr_sel_a),
        .we_port(we_port_a), .we_any(we_any_a),
        .conflict(conflict_a), .conflict_cnt(cnt_a)
    );

    regfile_we_decoder #(.ZERO_REG_EN(1'b0)) u_nz (
        .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
        .wr_en(wr_en_a), .wr_sel(wr_sel_a),
        .we_port(we_port_n), .we_any(we_any_n),
        .conflict(conflict_n), .conflict_cnt(cnt_n)
    );

    regfile_we_decoder #(.CNT_W(2)) u_sat (
        .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
        .wr_en(wr_en_a), .wr_sel(wr_sel_a),
        .we_port(we_port_s), .we_any(we_any_s),
        .conflict(conflict_s), .conflict_cnt(cnt_s)
    );

    regfile_we_decoder #(.NUM_PORTS(3), .SEL_W(4), .ZERO_REG_IDX(15)) u_p3 (
        .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
        .wr_en(wr_en_c), .wr_sel(wr_sel_c),
        .we_port(we_port_c), .we_any(we_any_c),
        .conflict(conflict_c), .conflict_cnt(cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle past it before sampling or re-driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [1:0] en, input logic [4:0] s0, input logic [4:0] s1);
        wr_en_a  = en;
        wr_sel_a = {s1, s0};
    endtask

    initial begin
        logic [63:0] exp64;
        logic [47:0] exp48;
        n_vec    = 0;
        n_err    = 0;
        reset_n  = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        wr_en_a  = '0;
        wr_sel_a = '0;
        wr_en_c  = '0;
        wr_sel_c = '0;

        tick();
        tick();
        check_val("rst_we_port", we_port_a, 64'h0);
        check_val("rst_cnt",     64'(cnt_a), 64'h0);
        reset_n = 1'b1;

        // Single decode.
        drive_a(2'b01, 5'd3, 5'd0);
        tick();
        check_val("dec3_port", we_port_a, 64'h0000_0000_0000_0008);
        check_val("dec3_any",  64'(we_any_a), 64'h8);
        check_val("dec3_conf", 64'(conflict_a), 64'h0);

        // Conflict on reg 7, four times back to back.
        drive_a(2'b11, 5'd7, 5'd7);
        tick();
        check_val("conf1_port", we_port_a, 64'h0000_0000_0000_0080);
        check_val("conf1_conf", 64'(conflict_a), 64'h1);
        check_val("conf1_cnt",  64'(cnt_a), 64'h1);
        tick();
        tick();
        check_val("conf3_cnt",  64'(cnt_a), 64'h3);
        check_val("sat3_cnt",   64'(cnt_s), 64'h3);
        tick();
        check_val("conf4_cnt",  64'(cnt_a), 64'h4);
        check_val("sat4_cnt",   64'(cnt_s), 64'h3);

        // Both ports on the zero register.
        drive_a(2'b11, 5'd31, 5'd31);
        tick();
        check_val("zr_any",     64'(we_any_a), 64'h0);
        check_val("zr_conf",    64'(conflict_a), 64'h0);
        check_val("zr_cnt",     64'(cnt_a), 64'h4);
        check_val("nz_port",    we_port_n, 64'h0000_0000_8000_0000);
        check_val("nz_conf",    64'(conflict_n), 64'h1);
        check_val("nz_cnt",     64'(cnt_n), 64'h5);

        // Stall holds, including across a conflict.
        drive_a(2'b01, 5'd5, 5'd0);
        tick();
        check_val("ld5_port", we_port_a, 64'h20);
        stall = 1'b1;
        drive_a(2'b01, 5'd9, 5'd0);
        tick();
        check_val("stall_port", we_port_a, 64'h20);
        check_val("stall_any",  64'(we_any_a), 64'h20);
        drive_a(2'b11, 5'd7, 5'd7);
        tick();
        check_val("stallc_port", we_port_a, 64'h20);
        check_val("stallc_conf", 64'(conflict_a), 64'h0);
        check_val("stallc_cnt",  64'(cnt_a), 64'h4);

        // Flush overrides stall; counter untouched.
        flush = 1'b1;
        tick();
        check_val("flush_port", we_port_a, 64'h0);
        check_val("flush_any",  64'(we_any_a), 64'h0);
        check_val("flush_cnt",  64'(cnt_a), 64'h4);
        stall = 1'b0;
        flush = 1'b0;

        // Conflict after flush: main counter moves, 2-bit one stays saturated.
        tick();
        check_val("conf5_cnt", 64'(cnt_a), 64'h5);
        check_val("conf5_conf", 64'(conflict_a), 64'h1);
        check_val("sat5_cnt",  64'(cnt_s), 64'h3);

        // Distinct targets, no conflict.
        drive_a(2'b11, 5'd2, 5'd4);
        tick();
        check_val("dual_port", we_port_a, 64'h0000_0010_0000_0004);
        check_val("dual_any",  64'(we_any_a), 64'h14);
        check_val("dual_conf", 64'(conflict_a), 64'h0);

        // No requests.
        drive_a(2'b00, 5'd6, 5'd6);
        tick();
        check_val("idle_port", we_port_a, 64'h0);
        check_val("idle_cnt",  64'(cnt_a), 64'h5);

        // Sweep every index on every port, one port active at a time.
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 32; i++) begin
                wr_en_a  = '0;
                wr_sel_a = '0;
                wr_en_c  = '0;
                wr_sel_c = '0;
                if (p < 2) begin
                    wr_en_a[p] = 1'b1;
                    wr_sel_a[p*5 +: 5] = i[4:0];
                end
                if (i < 16) begin
                    wr_en_c[p] = 1'b1;
                    wr_sel_c[p*4 +: 4] = i[3:0];
                end
                tick();
                if (p < 2) begin
                    exp64 = '0;
                    if (i != 31) exp64[p*32 + i] = 1'b1;
                    check_val($sformatf("sw5_p%0d_s%0d", p, i), we_port_a, exp64);
                    exp64 = '0;
                    exp64[p*32 + i] = 1'b1;
                    check_val($sformatf("swnz_p%0d_s%0d", p, i), we_port_n, exp64);
                end
                if (i < 16) begin
                    exp48 = '0;
                    if (i != 15) exp48[p*16 + i] = 1'b1;
                    check_val($sformatf("sw4_p%0d_s%0d", p, i), 64'(we_port_c), 64'(exp48));
                end
            end
        end
        check_val("sweep_cnt", 64'(cnt_a), 64'h5);

        // Three-way conflict on the 3-port variant.
        wr_en_c  = 3'b111;
        wr_sel_c = {4'd6, 4'd6, 4'd6};
        tick();
        check_val("p3_port", 64'(we_port_c), 64'h0000_0000_0040);
        check_val("p3_conf", 64'(conflict_c), 64'h1);
        check_val("p3_cnt",  64'(cnt_c), 64'h1);

        // Asynchronous reset mid-operation, sampled before the next edge.
        drive_a(2'b01, 5'd3, 5'd0);
        tick();
        check_val("pre_rst_port", we_port_a, 64'h8);
        reset_n = 1'b0;
        #2;
        check_val("arst_port", we_port_a, 64'h0);
        check_val("arst_any",  64'(we_any_a), 64'h0);
        check_val("arst_conf", 64'(conflict_a), 64'h0);
        check_val("arst_cnt",  64'(cnt_a), 64'h0);
        tick();
        reset_n = 1'b1;
        tick();
        check_val("post_rst_port", we_port_a, 64'h8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
